sync_gather_fifo: RTL and testbench



---
 rtl/sync_gather_fifo_pkg.sv | 22 ++
 rtl/gather_word_mux.sv | 34 +++
 rtl/sync_gather_fifo.sv | 157 +++++++++++++++
 tb/tb_sync_gather_fifo.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/sync_gather_fifo_pkg.sv
// sync_gather_fifo_pkg
//   Shared helpers for the gather FIFO:
//     ptr_w(depth)       - read/write pointer width (one extra wrap bit)
//     occupancy(...)     - entries held, from the two pointers
//     EMPTY_WORD_VALUE   - fill bit for words no thread was selected for
package sync_gather_fifo_pkg;

  localparam bit EMPTY_WORD_VALUE = '0;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Pointers run modulo 2*depth. Because depth is a power of two, the
  // 32-bit unsigned difference reduced modulo 2*depth gives the occupancy.
  function automatic int unsigned occupancy(input int unsigned wptr,
                                            input int unsigned rptr,
                                            input int unsigned depth);
    return (wptr - rptr) % (2 * depth);
  endfunction

endpackage

// File: rtl/gather_word_mux.sv
// gather_word_mux
//   Purely combinational selector for one FIFO word. It picks the data of
//   the highest-indexed thread whose enable bit is set. If no bit is set,
//   the word is the empty value and o_hit is low.
//   Ports:
//     i_data    [THREADS-1:0][WORD_WIDTH-1:0]  per-thread write data
//     i_enables [THREADS-1:0]                  thread-select bits for this word
//     o_word    [WORD_WIDTH-1:0]               selected word, or empty value
//     o_hit                                    at least one enable was set
module gather_word_mux
  import sync_gather_fifo_pkg::*;
#(
  parameter int WORD_WIDTH = 32,
  parameter int THREADS    = 4
) (
  input  logic [THREADS-1:0][WORD_WIDTH-1:0] i_data,
  input  logic [THREADS-1:0]                 i_enables,
  output logic [WORD_WIDTH-1:0]              o_word,
  output logic                               o_hit
);

  // Ascending scan: a later (higher) set index overrides earlier ones.
  always_comb begin
    o_word = {WORD_WIDTH{EMPTY_WORD_VALUE}};
    o_hit  = 1'b0;
    for (int unsigned t = 0; t < THREADS; t++) begin
      if (i_enables[t]) begin
        o_word = i_data[t];
        o_hit  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sync_gather_fifo.sv
// sync_gather_fifo
//   Single-clock first-word-fall-through FIFO, DEPTH entries of WORDS words.
//   On a push, each word is gathered from the highest-indexed enabled writer
//   thread. If no thread is enabled for a word, that word is written as zero.
//   Overflow and underflow are sticky until reset.
//   Optional macro SYNC_GATHER_FIFO_OCCUPANCY_EN adds o_count and
//   o_almost_full (o_count >= AF_LEVEL).
//   Ports:
//     i_clk, i_rst       clock, asynchronous active-high reset
//     i_w_push           push request
//     i_w_data           [THREADS][WORD_WIDTH] per-thread write data
//     i_w_enables        [WORDS][THREADS] per-word thread-select bits
//     o_w_full           FIFO holds DEPTH entries
//     o_w_overflow       sticky: a push was dropped
//     i_r_pull           pop request
//     o_r_data           [WORDS][WORD_WIDTH] head entry
//     o_r_available      FIFO non-empty
//     o_r_underflow      sticky: a pull arrived while empty
//     o_count            (optional) occupancy
//     o_almost_full      (optional) occupancy >= AF_LEVEL
module sync_gather_fifo
  import sync_gather_fifo_pkg::*;
#(
  parameter int WORD_WIDTH = 32,
  parameter int WORDS      = 4,
  parameter int THREADS    = 4,
  parameter int DEPTH      = 8,
  parameter int AF_LEVEL   = 6
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic                               i_w_push,
  input  logic [THREADS-1:0][WORD_WIDTH-1:0] i_w_data,
  input  logic [WORDS-1:0][THREADS-1:0]      i_w_enables,
  output logic                               o_w_full,
  output logic                               o_w_overflow,
  input  logic                               i_r_pull,
  output logic [WORDS-1:0][WORD_WIDTH-1:0]   o_r_data,
  output logic                               o_r_available,
  output logic                               o_r_underflow
`ifdef SYNC_GATHER_FIFO_OCCUPANCY_EN
  ,
  output logic [$clog2(DEPTH):0]             o_count,
  output logic                               o_almost_full
`endif
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  typedef logic [WORDS-1:0][WORD_WIDTH-1:0] entry_t;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_gather_fifo: DEPTH must be a power of two >= 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("sync_gather_fifo: AF_LEVEL must be in 1..DEPTH");
  end

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic            overflow_q, overflow_d;
  logic            underflow_q, underflow_d;

  entry_t          gathered;
  logic            empty;
  logic            full;
  logic            pull_ok;
  logic            push_ok;

  for (genvar w = 0; w < WORDS; w++) begin : g_word
    logic [WORD_WIDTH-1:0] mux_word;
    logic                  mux_hit;

    gather_word_mux #(
      .WORD_WIDTH (WORD_WIDTH),
      .THREADS    (THREADS)
    ) u_mux (
      .i_data    (i_w_data),
      .i_enables (i_w_enables[w]),
      .o_word    (mux_word),
      .o_hit     (mux_hit)
    );

    assign gathered[w] = mux_hit ? mux_word : {WORD_WIDTH{EMPTY_WORD_VALUE}};
  end

  // Flags come only from registered pointers, so they never follow the
  // push/pull inputs combinationally.
  always_comb begin
    empty = (wptr_q == rptr_q);
    full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  end

  // When full, a pull in the same cycle frees the slot the push needs.
  // When empty, a pull is ignored, so push+pull on empty stores the entry.
  always_comb begin
    pull_ok = i_r_pull & ~empty;
    push_ok = i_w_push & (~full | pull_ok);
  end

  always_comb begin
    mem_d       = mem_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    overflow_d  = overflow_q  | (i_w_push & ~push_ok);
    underflow_d = underflow_q | (i_r_pull & empty & ~i_w_push);
    if (push_ok) begin
      mem_d[wptr_q[AW-1:0]] = gathered;
      wptr_d                = wptr_q + PW'(1);
    end
    if (pull_ok) begin
      rptr_d = rptr_q + PW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q      <= '0;
      rptr_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_comb begin
    o_r_data      = mem_q[rptr_q[AW-1:0]];
    o_r_available = ~empty;
    o_w_full      = full;
    o_w_overflow  = overflow_q;
    o_r_underflow = underflow_q;
  end

`ifdef SYNC_GATHER_FIFO_OCCUPANCY_EN
  localparam int unsigned AF_U = AF_LEVEL;

  int unsigned occ;

  always_comb begin
    occ           = occupancy(32'(wptr_q), 32'(rptr_q), DEPTH);
    o_count       = PW'(occ);
    o_almost_full = (occ >= AF_U);
  end
`endif

endmodule

// File: tb/tb_sync_gather_fifo.sv
module tb_sync_gather_fifo;

  localparam int W  = 32;
  localparam int NW = 4;
  localparam int NT = 4;
  localparam int D  = 8;
  localparam int AF = 6;

  typedef logic [NW-1:0][W-1:0]  data_t;
  typedef logic [NT-1:0][W-1:0]  tdata_t;
  typedef logic [NW-1:0][NT-1:0] en_t;

  typedef struct {
    logic   push;
    logic   pull;
    en_t    en;
    tdata_t data;
    logic   avail;
    logic   full;
    logic   ovf;
    logic   unf;
    logic   chk_d;
    data_t  exp_d;
  } vec_t;

  localparam en_t DIAG = 16'h8421;

  logic   clk = 1'b0;
  logic   rst;
  logic   push, pull;
  tdata_t wdata;
  en_t    en;
  logic   full, ovf, avail, unf;
  data_t  rdata;
`ifdef SYNC_GATHER_FIFO_OCCUPANCY_EN
  logic [$clog2(D):0] count;
  logic               af;
`endif

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  sync_gather_fifo #(
    .WORD_WIDTH (W),
    .WORDS      (NW),
    .THREADS    (NT),
    .DEPTH      (D),
    .AF_LEVEL   (AF)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_w_push      (push),
    .i_w_data      (wdata),
    .i_w_enables   (en),
    .o_w_full      (full),
    .o_w_overflow  (ovf),
    .i_r_pull      (pull),
    .o_r_data      (rdata),
    .o_r_available (avail),
    .o_r_underflow (unf)
`ifdef SYNC_GATHER_FIFO_OCCUPANCY_EN
    ,
    .o_count       (count),
    .o_almost_full (af)
`endif
  );

  // Thread t carries base+t; with DIAG enables word w therefore reads base+w.
  function automatic tdata_t td(input logic [31:0] base);
    tdata_t r;
    for (int t = 0; t < NT; t++) r[t] = base + 32'(t);
    return r;
  endfunction

  function automatic vec_t mk(input logic p, input logic q, input en_t e,
                              input tdata_t d, input logic a, input logic f,
                              input logic o, input logic u, input logic c,
                              input data_t x);
    vec_t v;
    v.push = p; v.pull = q; v.en = e; v.data = d;
    v.avail = a; v.full = f; v.ovf = o; v.unf = u; v.chk_d = c; v.exp_d = x;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_flags(input string tag, input logic a, input logic f,
                           input logic o, input logic u);
    chk({tag, ".avail"}, 128'(avail), 128'(a));
    chk({tag, ".full"},  128'(full),  128'(f));
    chk({tag, ".ovf"},   128'(ovf),   128'(o));
    chk({tag, ".unf"},   128'(unf),   128'(u));
  endtask

  task automatic cycle(input logic p, input logic q, input en_t e,
                       input tdata_t d);
    @(negedge clk);
    push = p; pull = q; en = e; wdata = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; push = 1'b0; pull = 1'b0; en = '0; wdata = '0;
    #1;
    chk_flags("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst.data", 128'(rdata), 128'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // ---------------- vector table ----------------
    // idle after reset
    vecs.push_back(mk(0, 0, '0, '0, 0, 0, 0, 0, 1, '0));
    // diagonal gather
    vecs.push_back(mk(1, 0, DIAG, td(32'hA0), 1, 0, 0, 0, 1, td(32'hA0)));
    vecs.push_back(mk(0, 1, '0, '0, 0, 0, 0, 0, 0, '0));
    // word0 1010 -> thread3, word1 none -> 0, word2 0001 -> thread0,
    // word3 1111 -> thread3
    vecs.push_back(mk(1, 0, {4'b1111, 4'b0001, 4'b0000, 4'b1010}, td(32'hB0),
                      1, 0, 0, 0, 1,
                      {32'hB3, 32'hB0, 32'h0, 32'hB3}));
    vecs.push_back(mk(0, 1, '0, '0, 0, 0, 0, 0, 0, '0));
    // push+pull while empty: entry stored, no underflow
    vecs.push_back(mk(1, 1, DIAG, td(32'hC0), 1, 0, 0, 0, 1, td(32'hC0)));
    vecs.push_back(mk(0, 1, '0, '0, 0, 0, 0, 0, 0, '0));
    // pull while empty
    vecs.push_back(mk(0, 1, '0, '0, 0, 0, 0, 1, 0, '0));
    // fill to DEPTH, head stays at the first entry
    for (int k = 1; k <= D; k++)
      vecs.push_back(mk(1, 0, DIAG, td(32'h1000 * k), 1, (k == D), 0, 1, 1,
                        td(32'h1000)));
    // push alone while full: dropped
    vecs.push_back(mk(1, 0, DIAG, td(32'hEE00), 1, 1, 1, 1, 1, td(32'h1000)));
    // push+pull while full: both accepted, still full
    vecs.push_back(mk(1, 1, DIAG, td(32'h9000), 1, 1, 1, 1, 1, td(32'h2000)));
    // drain: order preserved across the pointer wrap
    for (int k = 1; k <= D; k++) begin
      if (k <= 6)
        vecs.push_back(mk(0, 1, '0, '0, 1, 0, 1, 1, 1, td(32'h1000 * (k + 2))));
      else if (k == 7)
        vecs.push_back(mk(0, 1, '0, '0, 1, 0, 1, 1, 1, td(32'h9000)));
      else
        vecs.push_back(mk(0, 1, '0, '0, 0, 0, 1, 1, 0, '0));
    end

    for (int i = 0; i < vecs.size(); i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      cycle(vecs[i].push, vecs[i].pull, vecs[i].en, vecs[i].data);
      chk_flags(tag, vecs[i].avail, vecs[i].full, vecs[i].ovf, vecs[i].unf);
      if (vecs[i].chk_d) chk({tag, ".data"}, 128'(rdata), 128'(vecs[i].exp_d));
    end

    // ---------------- asynchronous reset mid-operation ----------------
    for (int k = 0; k < 5; k++) cycle(1, 0, DIAG, td(32'h5000 + 32'h100 * k));
    chk("fill5.data", 128'(rdata), 128'(td(32'h5000)));
    @(negedge clk);
    push = 1'b0; pull = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_flags("arst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("arst.data", 128'(rdata), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    cycle(1, 0, DIAG, td(32'hA0));
    chk_flags("post_rst.push", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("post_rst.data", 128'(rdata), 128'(td(32'hA0)));
    cycle(0, 1, '0, '0);
    chk_flags("post_rst.pull", 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef SYNC_GATHER_FIFO_OCCUPANCY_EN
    chk("occ.count0", 128'(count), 128'(0));
    for (int k = 1; k <= D; k++) begin
      cycle(1, 0, DIAG, td(32'h7000 + 32'(k)));
      chk($sformatf("occ.count%0d", k), 128'(count), 128'(k));
      chk($sformatf("occ.af%0d", k), 128'(af), 128'(k >= AF));
    end
    for (int k = D - 1; k >= 5; k--) begin
      cycle(0, 1, '0, '0);
      chk($sformatf("occ.pull_count%0d", k), 128'(count), 128'(k));
      chk($sformatf("occ.pull_af%0d", k), 128'(af), 128'(k >= AF));
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
